// File: rtl/piece_queue.sv
// Random piece supplier: free-running 16-bit LFSR feeding a small preview FIFO, popped on take.
// Optional 7-bag randomizer enabled by defining PIECE_QUEUE_BAG7_EN.
module piece_queue #(
   parameter int unsigned XSIZE   = 3,
   parameter int unsigned YSIZE   = 3,
   parameter int unsigned DEPTH   = 2,
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int unsigned SPAWN_X = 3,
   parameter int unsigned SPAWN_Y = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             take,
   input  logic             seed_load,
   input  logic [15:0]      seed,
   output logic             valid,
   output logic [2:0]       pieceType,
   output logic             nextValid,
   output logic [2:0]       nextType,
   output logic             spawn,
   output logic [2:0]       activeType,
   output logic [XSIZE:0]   inX,
   output logic [YSIZE:0]   inY
);

   localparam int unsigned   CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [XSIZE:0] SPX    = SPAWN_X[XSIZE:0];
   localparam logic [YSIZE:0] SPY    = SPAWN_Y[YSIZE:0];

   typedef enum logic {FILL, FULL} state_t;

   state_t          state_q, state_d;
   logic [15:0]     lfsr_q, lfsr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [2:0]      fifo_q [DEPTH];
   logic [2:0]      fifo_d [DEPTH];
   logic            spawn_q, spawn_d;
   logic [2:0]      act_q, act_d;
   logic [XSIZE:0]  inx_q, inx_d;
   logic [YSIZE:0]  iny_q, iny_d;

   logic [2:0]      cand;
   logic            pop, push, accept;
   logic [CW-1:0]   cnt_after;

   assign cand = lfsr_q[2:0];

`ifdef PIECE_QUEUE_BAG7_EN
   logic [6:0] mask_q, mask_d, mask_set, mask_or;

   // Code c occupies mask bit c-1; code 0 is never accepted.
   assign mask_set = 7'd1 << (cand - 3'd1);
   assign mask_or  = mask_q | mask_set;
   assign accept   = (cand != 3'd0) && ((mask_q & mask_set) == '0);

   always_comb begin
      mask_d = mask_q;
      if (seed_load)
         mask_d = '0;
      else if (push)
         mask_d = (mask_or == '1) ? '0 : mask_or;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mask_q <= '0;
      else       mask_q <= mask_d;
   end
`else
   assign accept = 1'b1;
`endif

   assign pop       = take && (count_q != '0) && !seed_load;
   assign cnt_after = count_q - CW'(pop);
   assign push      = !seed_load && accept && ((state_q == FILL) || pop);

   always_comb begin
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      count_d = cnt_after + CW'(push);
      fifo_d  = fifo_q;
      state_d = state_q;
      spawn_d = pop;
      act_d   = pop ? fifo_q[0] : act_q;
      inx_d   = pop ? SPX : inx_q;
      iny_d   = pop ? SPY : iny_q;
      if (pop) begin
         for (int unsigned i = 0; i < DEPTH - 1; i++)
            fifo_d[i] = fifo_q[i+1];
         fifo_d[DEPTH-1] = '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++)
         if (push && (cnt_after == CW'(i)))
            fifo_d[i] = cand;
      if (seed_load) begin
         lfsr_d  = (seed == '0) ? SEED : seed;
         count_d = '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            fifo_d[i] = '0;
         state_d = FILL;
      end else begin
         case (state_q)
            FILL:    if (count_d == DEPTH_C) state_d = FULL;
            FULL:    if (pop && !push)       state_d = FILL;
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FILL;
         lfsr_q  <= SEED;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            fifo_q[i] <= '0;
         spawn_q <= 1'b0;
         act_q   <= '0;
         inx_q   <= SPX;
         iny_q   <= SPY;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         count_q <= count_d;
         fifo_q  <= fifo_d;
         spawn_q <= spawn_d;
         act_q   <= act_d;
         inx_q   <= inx_d;
         iny_q   <= iny_d;
      end
   end

   assign valid      = (count_q != '0);
   assign nextValid  = (count_q >= CW'(2));
   assign pieceType  = valid ? fifo_q[0] : '0;
   assign nextType   = nextValid ? fifo_q[1] : '0;
   assign spawn      = spawn_q;
   assign activeType = act_q;
   assign inX        = inx_q;
   assign inY        = iny_q;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue (DEPTH=2, SEED=ACE1, spawn at 3,0).
// Raw-mode vectors by default; 7-bag grouping check when PIECE_QUEUE_BAG7_EN is defined.
module tb_piece_queue;

   logic        clk = 1'b0;
   logic        reset, take, seed_load;
   logic [15:0] seed;
   logic        valid, nextValid, spawn;
   logic [2:0]  pieceType, nextType, activeType;
   logic [3:0]  inX, inY;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   piece_queue #(
      .XSIZE(3), .YSIZE(3), .DEPTH(2), .SEED(16'hACE1), .SPAWN_X(3), .SPAWN_Y(0)
   ) dut (
      .clk(clk), .reset(reset), .take(take), .seed_load(seed_load), .seed(seed),
      .valid(valid), .pieceType(pieceType), .nextValid(nextValid), .nextType(nextType),
      .spawn(spawn), .activeType(activeType), .inX(inX), .inY(inY)
   );

   typedef struct {
      logic        take;
      logic        sl;
      logic [15:0] seed;
      logic        v;
      logic [2:0]  pt;
      logic        nv;
      logic [2:0]  nt;
      logic        sp;
      logic [2:0]  act;
   } vec_t;

   function automatic logic [31:0] pk(input logic v, input logic [2:0] pt, input logic nv,
                                      input logic [2:0] nt, input logic sp, input logic [2:0] act);
      return {12'h0, v, pt, nv, nt, sp, act, 4'd3, 4'd0};
   endfunction

   task automatic chkv(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] exp);
      chkv(nm, {12'h0, valid, pieceType, nextValid, nextType, spawn, activeType, inX, inY}, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

`ifdef PIECE_QUEUE_BAG7_EN
   logic [2:0] codes [70];
   int         n;
   logic [7:0] seen;
`else
   vec_t vecs [13];
`endif

   initial begin
      reset = 1'b1; take = 1'b0; seed_load = 1'b0; seed = '0;
      #2;
      chk("reset_values", pk(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 reset = 1'b0;

`ifdef PIECE_QUEUE_BAG7_EN
      n = 0;
      take = 1'b1;
      for (int c = 0; c < 5000 && n < 70; c++) begin
         step();
         if (spawn) begin
            codes[n] = activeType;
            n++;
         end
      end
      take = 1'b0;
      chkv("bag_take_count", 32'(n), 32'd70);
      for (int g = 0; g < 10; g++) begin
         seen = '0;
         for (int k = 0; k < 7; k++) begin
            if (g * 7 + k < n) begin
               if (seen[codes[g*7+k]]) seen = 8'hFF;
               else seen[codes[g*7+k]] = 1'b1;
            end
         end
         chkv($sformatf("bag_group_%0d", g), {24'h0, seen}, 32'h0000_00FE);
      end
`else
      // LFSR candidates from ACE1: 1,3,7,7,6,4,1,2,...
      vecs[0]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0};
      vecs[1]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd1, 1'b1, 3'd3, 1'b0, 3'd0};
      vecs[2]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd1, 1'b1, 3'd3, 1'b0, 3'd0};
      vecs[3]  = '{1'b1, 1'b0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1, 3'd1};
      vecs[4]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd7, 1'b0, 3'd1};
      vecs[5]  = '{1'b1, 1'b0, 16'h0, 1'b1, 3'd7, 1'b1, 3'd4, 1'b1, 3'd3};
      vecs[6]  = '{1'b1, 1'b0, 16'h0, 1'b1, 3'd4, 1'b1, 3'd1, 1'b1, 3'd7};
      vecs[7]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd4, 1'b1, 3'd1, 1'b0, 3'd7};
      vecs[8]  = '{1'b1, 1'b1, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7};
      vecs[9]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd7};
      vecs[10] = '{1'b1, 1'b0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd1};
      vecs[11] = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd7, 1'b0, 3'd1};
      vecs[12] = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd7, 1'b0, 3'd1};

      for (int i = 0; i < 13; i++) begin
         take = vecs[i].take; seed_load = vecs[i].sl; seed = vecs[i].seed;
         step();
         chk($sformatf("vec_%0d", i),
             pk(vecs[i].v, vecs[i].pt, vecs[i].nv, vecs[i].nt, vecs[i].sp, vecs[i].act));
      end
      take = 1'b0; seed_load = 1'b0; seed = '0;

      // Seed 1234 gives candidates 4 then 1; a reload must reproduce them.
      for (int r = 0; r < 2; r++) begin
         seed_load = 1'b1; seed = 16'h1234;
         step();
         seed_load = 1'b0;
         chk($sformatf("seed_flush_%0d", r), pk(0, 0, 0, 0, 0, r == 0 ? 3'd1 : 3'd4));
         step();
         chk($sformatf("seed_first_%0d", r), pk(1, 4, 0, 0, 0, r == 0 ? 3'd1 : 3'd4));
         step();
         chk($sformatf("seed_second_%0d", r), pk(1, 4, 1, 1, 0, r == 0 ? 3'd1 : 3'd4));
         take = 1'b1;
         step();
         take = 1'b0;
         chkv($sformatf("seed_pop_%0d", r), {28'h0, spawn, activeType}, {28'h0, 1'b1, 3'd4});
         chkv($sformatf("seed_head_%0d", r), {29'h0, pieceType}, 32'd1);
         step();
         step();
      end

      // Full FIFO, take held, reset asserted mid-cycle.
      take = 1'b1;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_reset", pk(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 reset = 1'b0;
      step();
      chk("take_when_empty", pk(1, 1, 0, 0, 0, 0));
      take = 1'b0;
      step();
      chk("refill_after_reset", pk(1, 1, 1, 3, 0, 0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
